// File: rtl/video_in_pkg.sv
// Shared types and helpers for the BT.656 video-input receiver:
// TRS parser states, XY bit positions and TRS/XY byte helpers.
package video_in_pkg;

  typedef enum logic [1:0] {
    TRS_DATA = 2'd0,
    TRS_FF1  = 2'd1,
    TRS_Z1   = 2'd2,
    TRS_Z2   = 2'd3
  } trs_state_e;

  localparam int XY_F_BIT = 6;
  localparam int XY_V_BIT = 5;
  localparam int XY_H_BIT = 4;

  // TRS detection works on the top 8 bits so 10-bit streams decode identically.
  function automatic logic trs_ones(input logic [7:0] top8);
    return (top8 == 8'hFF);
  endfunction

  function automatic logic trs_zero(input logic [7:0] top8);
    return (top8 == 8'h00);
  endfunction

  function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/video_in_fifo.sv
// Synchronous show-ahead FIFO; full/empty come from read/write pointers
// carrying one extra wrap bit.
module video_in_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // Head is forced to zero when empty so a freshly reset FIFO shows no stale data.
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance on push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en) wr_ptr_r <= wr_ptr_r + PTR_INC;
      if (rd_en) rd_ptr_r <= rd_ptr_r + PTR_INC;
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (wr_en) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/video_in_bt656_rx.sv
// BT.656 receiver: TRS parsing, 4:2:2 packing into {chroma, luma} words and a
// show-ahead output FIFO. Define VIDEO_IN_XY_CHECK_EN to check XY protection bits.
module video_in_bt656_rx
  import video_in_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_sol,
  output logic                out_field,
  output logic [CNT_W-1:0]    field_lines,
  output logic                overflow_flag,
  input  logic                clear_overflow,
  output logic                xy_err
);
  localparam int WORD_W = 2 * DATA_W;
  localparam int FIFO_W = WORD_W + 2;

  logic              in_valid_r;
  logic [DATA_W-1:0] in_data_r;
  logic [7:0]        top8_s;
  trs_state_e        trs_state_r;
  trs_state_e        trs_next_s;
  logic              is_ones_s, is_zero_s;
  logic              xy_seen_s, xy_bad_s, xy_ok_s, pixel_s;
  logic              xy_f_s, xy_v_s, xy_h_s;

  logic              active_r, field_r, phase_r, drop_r, sol_pend_r, v_prev_r;
  logic [DATA_W-1:0] chroma_r;
  logic              pack_valid_r, pack_sol_r, pack_field_r;
  logic [WORD_W-1:0] pack_data_r;
  logic [CNT_W-1:0]  line_cnt_r, field_lines_r;
  logic              overflow_r, xy_err_r;

  logic              fifo_full_s, fifo_empty_s, pop_s, wr_try_s, wr_en_s, wr_fail_s;
  logic [FIFO_W-1:0] fifo_head_s;

  assign top8_s = in_data_r[DATA_W-1 -: 8];
  assign xy_f_s = top8_s[XY_F_BIT];
  assign xy_v_s = top8_s[XY_V_BIT];
  assign xy_h_s = top8_s[XY_H_BIT];

  // Input sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_valid_r <= 1'b0;
      in_data_r  <= {DATA_W{1'b0}};
    end else begin
      in_valid_r <= in_valid;
      in_data_r  <= in_data;
    end
  end

  // Byte classification, TRS next state and XY acceptance
  always_comb begin
    is_ones_s  = trs_ones(top8_s);
    is_zero_s  = trs_zero(top8_s);
    trs_next_s = TRS_DATA;
    case (trs_state_r)
      TRS_DATA: begin
        if (is_ones_s) trs_next_s = TRS_FF1;
        else           trs_next_s = TRS_DATA;
      end
      TRS_FF1: begin
        if (is_zero_s)      trs_next_s = TRS_Z1;
        else if (is_ones_s) trs_next_s = TRS_FF1;
        else                trs_next_s = TRS_DATA;
      end
      TRS_Z1: begin
        if (is_zero_s)      trs_next_s = TRS_Z2;
        else if (is_ones_s) trs_next_s = TRS_FF1;
        else                trs_next_s = TRS_DATA;
      end
      TRS_Z2:  trs_next_s = TRS_DATA;
      default: trs_next_s = TRS_DATA;
    endcase
    xy_seen_s = in_valid_r && (trs_state_r == TRS_Z2);
`ifdef VIDEO_IN_XY_CHECK_EN
    xy_bad_s = (top8_s[3:0] != xy_prot(xy_f_s, xy_v_s, xy_h_s));
`else
    xy_bad_s = 1'b0;
`endif
    xy_ok_s = xy_seen_s && !xy_bad_s;
    // Bytes rejected part-way through a TRS fall back to ordinary data bytes.
    pixel_s = in_valid_r && active_r && (trs_state_r != TRS_Z2) && !is_ones_s && !is_zero_s;
  end

  assign pop_s     = !fifo_empty_s && out_ready;
  assign wr_try_s  = pack_valid_r && !drop_r;
  assign wr_en_s   = wr_try_s && (!fifo_full_s || pop_s);
  assign wr_fail_s = wr_try_s && fifo_full_s && !pop_s;

  // TRS FSM, line state and pixel packing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trs_state_r  <= TRS_DATA;
      active_r     <= 1'b0;
      field_r      <= 1'b0;
      phase_r      <= 1'b0;
      drop_r       <= 1'b0;
      sol_pend_r   <= 1'b0;
      v_prev_r     <= 1'b0;
      chroma_r     <= {DATA_W{1'b0}};
      pack_valid_r <= 1'b0;
      pack_sol_r   <= 1'b0;
      pack_field_r <= 1'b0;
      pack_data_r  <= {WORD_W{1'b0}};
    end else begin
      if (in_valid_r) trs_state_r <= trs_next_s;
      pack_valid_r <= 1'b0;
      if (wr_fail_s) drop_r <= 1'b1;
      if (xy_ok_s) begin
        v_prev_r <= xy_v_s;
        if (!xy_h_s) begin
          active_r   <= !xy_v_s;
          field_r    <= xy_f_s;
          phase_r    <= 1'b0;
          drop_r     <= 1'b0;
          sol_pend_r <= 1'b1;
        end else begin
          active_r <= 1'b0;
        end
      end else if (pixel_s) begin
        phase_r <= !phase_r;
        if (!phase_r) begin
          chroma_r <= in_data_r;
        end else begin
          pack_valid_r <= 1'b1;
          pack_data_r  <= {chroma_r, in_data_r};
          pack_sol_r   <= sol_pend_r;
          pack_field_r <= field_r;
          sol_pend_r   <= 1'b0;
        end
      end
    end
  end

  // Per-field line counting, overflow flag and XY error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_r    <= {CNT_W{1'b0}};
      field_lines_r <= {CNT_W{1'b0}};
      overflow_r    <= 1'b0;
      xy_err_r      <= 1'b0;
    end else begin
      xy_err_r <= xy_seen_s && xy_bad_s;
      if (xy_ok_s) begin
        if (xy_v_s && !v_prev_r) begin
          field_lines_r <= line_cnt_r;
          line_cnt_r    <= {CNT_W{1'b0}};
        end else if (!xy_h_s && !xy_v_s && (line_cnt_r != {CNT_W{1'b1}})) begin
          line_cnt_r <= line_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      // A new overflow outranks a simultaneous clear request.
      if (wr_fail_s)           overflow_r <= 1'b1;
      else if (clear_overflow) overflow_r <= 1'b0;
    end
  end

  video_in_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en_s),
    .wr_data ({pack_sol_r, pack_field_r, pack_data_r}),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  assign out_valid                     = !fifo_empty_s;
  assign {out_sol, out_field, out_data} = fifo_head_s;
  assign field_lines                   = field_lines_r;
  assign overflow_flag                 = overflow_r;
  assign xy_err                        = xy_err_r;

endmodule

// File: tb/tb_video_in_bt656_rx.sv
// Self-checking bench for video_in_bt656_rx: XY table, full line, overflow,
// reset mid-line and per-field line counting, checked through a word scoreboard.
module tb_video_in_bt656_rx;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 11;

  typedef struct packed {
    logic          sol;
    logic          field;
    logic [2*DW-1:0] data;
  } word_t;

  typedef struct {
    logic [7:0] xy;
    int         words;
    logic       field;
    int         xyerr;
  } row_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = 8'h00;
  logic            out_ready = 1'b0;
  logic            clear_overflow = 1'b0;
  logic            out_valid, out_sol, out_field, overflow_flag, xy_err;
  logic [2*DW-1:0] out_data;
  logic [CW-1:0]   field_lines;

  video_in_bt656_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sol        (out_sol),
    .out_field      (out_field),
    .field_lines    (field_lines),
    .overflow_flag  (overflow_flag),
    .clear_overflow (clear_overflow),
    .xy_err         (xy_err)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  word_t got_w, exp_w;
  int    errors = 0, checks = 0, pop_cnt = 0, xy_err_cnt = 0;
  int    ready_mode = 0, cyc = 0;
  logic  stall_r = 1'b0, ovf_with_clear = 1'b0;
  word_t held_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink: 0 = stalled, 1 = always ready, 2 = ready three cycles out of four
  always @(posedge clk) begin
    cyc++;
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ((cyc % 4) != 0);
    endcase
  end

  // Monitor on the falling edge: scoreboard pops, hold stability, pulse counts
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_r = 1'b0;
    end else begin
      got_w = {out_sol, out_field, out_data};
      if (xy_err) xy_err_cnt++;
      if (overflow_flag && clear_overflow) ovf_with_clear = 1'b1;
      if (stall_r) check("hold_stable", 32'({out_valid, got_w}), 32'({1'b1, held_w}));
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 32'(got_w), 32'(exp_w));
        end
      end
      stall_r = out_valid && !out_ready;
      held_w  = got_w;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Idle cycles present all-ones with in_valid low, which must be ignored.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send(8'hFF); send(8'h00); send(8'h00); send(xy);
  endtask

  task automatic send_line(input logic [7:0] sav, input logic [7:0] eav, input int npix,
                           input int keep, input bit gaps);
    logic [7:0] cb, y;
    word_t w;
    int k;
    send_trs(sav);
    for (int i = 0; i < npix; i++) begin
      k  = i / 2;
      cb = ((k % 2) == 0) ? 8'h80 : 8'h70;
      y  = 8'h10 + 8'(k % 200);
      if ((i % 2) == 0) begin
        send(cb);
      end else begin
        if (k < keep) begin
          w.sol = (k == 0); w.field = sav[6]; w.data = {cb, y};
          exp_q.push_back(w);
        end
        send(y);
      end
      if (gaps && ((i % 7) == 3)) tick();
    end
    send_trs(eav);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    row_t       tbl [8];
    int         p0, e0;
    logic [7:0] y;
    word_t      w;

    #1 reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sol_field", 32'({out_sol, out_field}), 32'd0);
    check("rst_field_lines", 32'(field_lines), 32'd0);
    check("rst_ovf_xyerr", 32'({overflow_flag, xy_err}), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    ready_mode = 1;
    tick();

    // XY table: SAV/EAV with each field and blanking combination, plus a corrupt XY
    tbl[0] = '{8'h80, 1, 1'b0, 0};
    tbl[1] = '{8'hC7, 1, 1'b1, 0};
    tbl[2] = '{8'h9D, 0, 1'b0, 0};
    tbl[3] = '{8'hEC, 0, 1'b1, 0};
    tbl[4] = '{8'hDA, 0, 1'b1, 0};
    tbl[5] = '{8'hF1, 0, 1'b1, 0};
`ifdef VIDEO_IN_XY_CHECK_EN
    tbl[6] = '{8'h81, 0, 1'b0, 1};
`else
    tbl[6] = '{8'h81, 1, 1'b0, 0};
`endif
    tbl[7] = '{8'h80, 1, 1'b0, 0};
    for (int r = 0; r < 8; r++) begin
      p0 = pop_cnt;
      e0 = xy_err_cnt;
      send_trs(tbl[r].xy);
      send(8'h55);
      y = 8'h60 + 8'(r);
      if (tbl[r].words != 0) begin
        w.sol = 1'b1; w.field = tbl[r].field; w.data = {8'h55, y};
        exp_q.push_back(w);
      end
      send(y);
      drain("row");
      check("row_words", 32'(pop_cnt - p0), 32'(tbl[r].words));
      check("row_xy_err", 32'(xy_err_cnt - e0), 32'(tbl[r].xyerr));
    end

    // Full 720-pixel line with input gaps and a back-pressuring sink
    ready_mode = 2;
    send_line(8'h80, 8'h9D, 720, 100000, 1'b1);
    ready_mode = 1;
    drain("line720");
    check("line720_no_ovf", 32'(overflow_flag), 32'd0);

    // Stalled sink for a whole line: FIFO keeps DEPTH words, rest of line dropped
    ready_mode = 0;
    tick(); tick();
    send_line(8'h80, 8'h9D, 720, DEPTH, 1'b0);
    repeat (4) tick();
    check("ovf_set", 32'(overflow_flag), 32'd1);
    check("ovf_full_valid", 32'(out_valid), 32'd1);
    ready_mode = 1;
    drain("ovf_keep");
    send_line(8'h80, 8'h9D, 8, 100000, 1'b0);
    drain("ovf_next_line");
    check("ovf_sticky", 32'(overflow_flag), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tick();
    check("ovf_cleared", 32'(overflow_flag), 32'd0);

    // Overflow while clear is held: the set must still be visible for a cycle
    ready_mode = 0;
    clear_overflow = 1'b1;
    ovf_with_clear = 1'b0;
    tick(); tick();
    send_line(8'h80, 8'h9D, 40, DEPTH, 1'b0);
    repeat (4) tick();
    check("ovf_set_beats_clear", 32'(ovf_with_clear), 32'd1);
    check("ovf_clear_after", 32'(overflow_flag), 32'd0);
    clear_overflow = 1'b0;
    ready_mode = 1;
    drain("ovf2");

    // Reset mid-line, then pixels without a SAV must produce nothing
    send_trs(8'h80);
    for (int i = 0; i < 12; i++) begin
      if ((i % 2) == 1) begin
        w.sol = (i == 1); w.field = 1'b0; w.data = {8'h80, 8'h20};
        exp_q.push_back(w);
        send(8'h20);
      end else begin
        send(8'h80);
      end
    end
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'({out_sol, out_field, out_data}), 32'd0);
    check("midrst_flags", 32'({overflow_flag, xy_err, field_lines}), 32'd0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    p0 = pop_cnt;
    for (int i = 0; i < 20; i++) send(((i % 2) == 1) ? 8'h21 : 8'h80);
    repeat (6) tick();
    check("post_rst_no_words", 32'(pop_cnt - p0), 32'd0);
    send_line(8'h80, 8'h9D, 16, 100000, 1'b0);
    drain("post_rst_line");

    // Per-field line count: 244 active lines then a V=1 SAV, and a restart
    do_reset();
    for (int l = 0; l < 244; l++) send_line(8'h80, 8'h9D, 4, 100000, 1'b0);
    check("fl_before", 32'(field_lines), 32'd0);
    send_trs(8'hAB);
    tick(); tick();
    check("fl_244", 32'(field_lines), 32'd244);
    send_trs(8'hB6);
    for (int l = 0; l < 3; l++) send_line(8'h80, 8'h9D, 4, 100000, 1'b0);
    check("fl_hold", 32'(field_lines), 32'd244);
    send_trs(8'hAB);
    tick(); tick();
    check("fl_restart_3", 32'(field_lines), 32'd3);
    drain("field");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_in_bt656_rx.md
# video_in_bt656_rx

Parametrised BT.656 video-input receiver. Sits between the TV decoder pins (TD_DATA/TD_CLK27 domain) and the video DMA. It parses the embedded timing reference codes (TRS) and packs active 4:2:2 bytes into {chroma, luma} words. Words are buffered in a FIFO with a ready/valid output. Adds width/depth generalisation, per-field line counting, line-drop recovery and a clearable sticky overflow flag.

## Interface
- `DATA_W`, 8, sample width (8 or 10); TRS/XY decoded from bits [DATA_W-1:DATA_W-8]
- `FIFO_DEPTH`, 16, output FIFO entries; power of 2, ≥4
- `CNT_W`, 11, width of line counter and `field_lines`
- `clk` in 1: single clock (27 MHz sample clock)
- `reset_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: `in_data` sample qualifier
- `in_data` in DATA_W: BT.656 byte stream
- `out_ready` in 1: sink accepts word
- `out_valid` out 1: FIFO head valid
- `out_data` out 2*DATA_W: {chroma, luma}
- `out_sol` out 1: word is first of an active line
- `out_field` out 1: F bit of the line carrying this word
- `field_lines` out CNT_W: active lines in last completed field
- `overflow_flag` out 1: sticky, a word was dropped
- `clear_overflow` in 1: clears `overflow_flag`
- `xy_err` out 1: one-cycle pulse, bad XY protection bits

## Operation
- Only cycles with `in_valid`=1 advance anything.
- TRS FSM states:
  - DATA: all-ones → FF1.
  - FF1: zero → Z1; else → DATA.
  - Z1: zero → Z2; else → DATA.
  - Z2: next byte is XY → DATA.
  - A non-matching byte in FF1/Z1 is re-evaluated as a DATA byte; all-ones restarts at FF1.
- XY fields: F = bit6, V = bit5, H = bit4 (relative to the top 8 bits).
  - H=0 (SAV): `active` = ~V; clears `phase` and `drop`; sets `sol_pend`.
  - H=1 (EAV): `active` = 0.
- Pixel bytes: while `active`, every byte not all-ones/all-zeros is a pixel byte. Order is Cb,Y,Cr,Y.
  - Chroma bytes are held.
  - Each luma byte forms the word {held chroma, luma}.
  - The first word after SAV carries `out_sol`=1; `out_field` = F latched at SAV.
- Line counter: increments on each SAV with V=0, saturating at all-ones.
  - On a V 0→1 transition (XY), the count is copied to `field_lines` and the counter is cleared.
- FIFO write when full:
  - The word is discarded and `overflow_flag` is set.
  - `drop` is set; all further words of that line are discarded until the next SAV, so SOL alignment is preserved.
- `clear_overflow` clears the flag. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM = DATA, `active`=0, FIFO empty.
  - `out_valid`=0, `out_data`=0, `out_sol`=0, `out_field`=0.
  - `field_lines`=0, `overflow_flag`=0, `xy_err`=0.
- Latency: a luma byte sampled at edge k gives `out_valid`=1 after edge k+2 (pack register, then FIFO write), with the FIFO empty and show-ahead.
- Handshake: a word transfers on edges where `out_valid`&&`out_ready`. `out_data`/`out_sol`/`out_field` are stable while `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop when full: the pop frees the slot, so the push succeeds and no overflow is raised.
- Reset mid-line: everything clears asynchronously; the block waits for the next SAV with V=0 before emitting.
- `field_lines` and `overflow_flag` are registered; they update the edge after the causing XY/overflow.

## Configuration
- `VIDEO_IN_XY_CHECK_EN` defined:
  - Protection bits are checked: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - On mismatch the XY is ignored (`active`, F and counters unchanged) and `xy_err` pulses for 1 cycle.
- Undefined: every XY is accepted; `xy_err` is tied to 0.

## Structure
- Shared package `video_in_pkg`:
  - TRS state enum.
  - XY bit-position constants.
  - `trs_ones(DATA_W)`/`trs_zero` helper functions.
- Sub-module `video_in_fifo`: synchronous show-ahead FIFO (DATA_W*2+2 bits, FIFO_DEPTH entries), with full/empty from a wrapped pointer (extra MSB).

## Test plan
- DATA_W=8: SAV(FF 00 00 80), then 80 10 80 11 … (720 px), then EAV(FF 00 00 9D) → 360 words {80,10},{80,11}…; first word `out_sol`=1, last word emitted before EAV.
- 244 active lines then XY with V=1 (AB) → `field_lines`=244 the edge after; counter restarts.
- `out_ready`=0 for a full line with FIFO_DEPTH=16 → 16 words kept, `overflow_flag`=1, rest of line dropped. Next line's first output has `out_sol`=1; `clear_overflow` then drops the flag.
- Overflow and `clear_overflow` in the same cycle → flag remains 1.
- With macro: XY=0x81 → `xy_err` pulse, no `active` change. Without macro: same XY → `active`=1, `xy_err`=0.
- `reset_n` low mid-line → all outputs 0 immediately; after release, no words appear until the next valid SAV.
